// File: rtl/hd_vector_driver.sv
// Stimulus source and response collector for 8-input one-output predicate blocks.
// Issues exhaustive or LFSR vector sweeps over valid/ready and folds the responses into hit/response counts and a MISR signature.
module hd_vector_driver #(
    parameter int               WIDTH   = 8,
    parameter logic [WIDTH-1:0] POLY    = 8'hB8,
    parameter int               MAX_OUT = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             mode,
    input  logic [WIDTH-1:0] seed,
    output logic             vec_valid,
    output logic [WIDTH-1:0] vec_data,
    input  logic             vec_ready,
    input  logic             res_valid,
    input  logic             res_bit,
    output logic             busy,
    output logic             done,
    output logic [WIDTH:0]   hit_count,
    output logic [WIDTH:0]   resp_count,
    output logic [15:0]      signature,
    output logic             error
);

    localparam int             OUT_W     = 4;
    localparam logic [OUT_W-1:0] OUT_CAP = OUT_W'(MAX_OUT);
    localparam logic [WIDTH:0] LAST_EXH  = {1'b0, {WIDTH{1'b1}}};
    localparam logic [WIDTH:0] LAST_LFSR = LAST_EXH - (WIDTH+1)'(1);

    typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, DONE} state_t;

    function automatic logic [WIDTH-1:0] next_vec(input logic [WIDTH-1:0] v, input logic lfsr);
        if (lfsr)
            next_vec = (v >> 1) ^ (v[0] ? POLY : '0);
        else
            next_vec = v + WIDTH'(1);
    endfunction

    function automatic logic [15:0] misr_step(input logic [15:0] s, input logic b);
        misr_step = {s[14:0], 1'b0} ^ (s[15] ? 16'h1021 : 16'h0000) ^ {15'b0, b};
    endfunction

    state_t           state;
    logic             mode_r;
    logic [WIDTH:0]   issue_cnt;
    logic [OUT_W-1:0] outstanding;

    logic             xfer;
    logic             resp_ok;
    logic             resp_err;
    logic             last_xfer;
    logic [OUT_W-1:0] out_nxt;

    always_comb begin
        xfer      = vec_valid & vec_ready;
        resp_ok   = res_valid & (outstanding != '0);
        resp_err  = res_valid & (outstanding == '0);
        out_nxt   = outstanding + OUT_W'(xfer) - OUT_W'(resp_ok);
        last_xfer = xfer & (issue_cnt == (mode_r ? LAST_LFSR : LAST_EXH));
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= IDLE;
            mode_r      <= 1'b0;
            issue_cnt   <= '0;
            outstanding <= '0;
            vec_valid   <= 1'b0;
            vec_data    <= '0;
            busy        <= 1'b0;
            done        <= 1'b0;
            hit_count   <= '0;
            resp_count  <= '0;
            signature   <= 16'hFFFF;
            error       <= 1'b0;
        end else begin
            outstanding <= out_nxt;
            if (resp_ok) begin
                resp_count <= resp_count + (WIDTH+1)'(1);
                hit_count  <= hit_count + (WIDTH+1)'(res_bit);
                signature  <= misr_step(signature, res_bit);
            end
            if (resp_err)
                error <= 1'b1;

            case (state)
                IDLE, DONE: begin
                    // A start here always sees outstanding == 0, so the first vector can go out immediately.
                    if (start) begin
                        state      <= ISSUE;
                        busy       <= 1'b1;
                        done       <= 1'b0;
                        mode_r     <= mode;
                        issue_cnt  <= '0;
                        vec_valid  <= 1'b1;
                        vec_data   <= mode ? ((seed == '0) ? WIDTH'(1) : seed) : '0;
                        hit_count  <= '0;
                        resp_count <= '0;
                        signature  <= 16'hFFFF;
                        error      <= 1'b0;
                    end
                end
                ISSUE: begin
                    if (last_xfer) begin
                        state     <= DRAIN;
                        vec_valid <= 1'b0;
                    end else begin
                        if (xfer) begin
                            issue_cnt <= issue_cnt + (WIDTH+1)'(1);
                            vec_data  <= next_vec(vec_data, mode_r);
                        end
                        // A pending vector is never withdrawn; a new one needs room under the cap.
                        vec_valid <= (vec_valid & ~vec_ready) | (out_nxt < OUT_CAP);
                    end
                end
                DRAIN: begin
                    if (outstanding == '0) begin
                        state <= DONE;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                    end
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                    done  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_hd_vector_driver.sv
// Directed bench for hd_vector_driver: a negedge-driven predicate model answers each
// transfer after a programmable delay while the tasks below check the collected results.
module tb_hd_vector_driver;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       start = 1'b0;
    logic       mode = 1'b0;
    logic [7:0] seed = 8'h00;
    logic       vec_valid;
    logic [7:0] vec_data;
    logic       vec_ready = 1'b0;
    logic       res_valid = 1'b0;
    logic       res_bit = 1'b0;
    logic       busy;
    logic       done;
    logic [8:0] hit_count;
    logic [8:0] resp_count;
    logic [15:0] signature;
    logic       error;

    hd_vector_driver #(.WIDTH(8), .POLY(8'hB8), .MAX_OUT(4)) dut (
        .clk(clk), .rst(rst), .start(start), .mode(mode), .seed(seed),
        .vec_valid(vec_valid), .vec_data(vec_data), .vec_ready(vec_ready),
        .res_valid(res_valid), .res_bit(res_bit), .busy(busy), .done(done),
        .hit_count(hit_count), .resp_count(resp_count), .signature(signature),
        .error(error)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;

    typedef struct {
        int   due;
        logic b;
    } pend_t;

    pend_t      pend[$];
    logic [7:0] vlog[$];
    int         clog[$];
    int         cyc = 0;
    int         resp_delay = 1;
    bit         resp_en = 1'b1;
    bit         resp_lsb = 1'b0;
    bit         rdy_pat = 1'b0;
    int         out_model = 0;
    int         max_out = 0;
    int         stable_viol = 0;
    bit         held_v = 1'b0;
    logic [7:0] held_d = 8'h00;

    function automatic logic [15:0] misr_model(input logic [15:0] s, input logic b);
        logic [15:0] r;
        r = s << 1;
        if (s[15]) r = r ^ 16'h1021;
        r[0] = r[0] ^ b;
        return r;
    endfunction

    // Predicate model: drives vec_ready/res_* for the coming posedge and logs transfers.
    always @(negedge clk) begin
        cyc = cyc + 1;
        if (rst) begin
            pend.delete();
            res_valid = 1'b0;
            vec_ready = 1'b0;
            out_model = 0;
            held_v = 1'b0;
        end else begin
            if (held_v && (!vec_valid || vec_data !== held_d))
                stable_viol = stable_viol + 1;
            if (rdy_pat)
                vec_ready = ((cyc % 4) == 0) || ((cyc % 4) == 3);
            else
                vec_ready = 1'b1;
            if (resp_en) begin
                if (pend.size() > 0 && pend[0].due == cyc) begin
                    res_valid = 1'b1;
                    res_bit = pend[0].b;
                    void'(pend.pop_front());
                    out_model = out_model - 1;
                end else begin
                    res_valid = 1'b0;
                end
            end
            if (vec_valid && vec_ready) begin
                vlog.push_back(vec_data);
                clog.push_back(cyc);
                pend.push_back('{due: cyc + resp_delay, b: (resp_lsb ? vec_data[0] : 1'b1)});
                out_model = out_model + 1;
                if (out_model > max_out) max_out = out_model;
            end
            held_v = vec_valid && !vec_ready;
            held_d = vec_data;
        end
    end

    task automatic do_start(input logic m, input logic [7:0] s);
        @(negedge clk);
        vlog.delete();
        clog.delete();
        max_out = 0;
        stable_viol = 0;
        start = 1'b1;
        mode = m;
        seed = s;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_done(input int bound, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < bound; i++) begin
            @(negedge clk);
            if (done) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic test_reset;
        repeat (3) @(negedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        checks++; if (vec_valid !== 1'b0) begin failures++; $display("FAIL reset_vec_valid got=%0b exp=0", vec_valid); end
        checks++; if (vec_data !== 8'h00) begin failures++; $display("FAIL reset_vec_data got=%0h exp=0", vec_data); end
        checks++; if (busy !== 1'b0 || done !== 1'b0) begin failures++; $display("FAIL reset_busy_done got=%0b%0b exp=00", busy, done); end
        checks++; if (hit_count !== 9'd0 || resp_count !== 9'd0) begin failures++; $display("FAIL reset_counts got=%0d/%0d exp=0/0", hit_count, resp_count); end
        checks++; if (signature !== 16'hFFFF) begin failures++; $display("FAIL reset_signature got=%0h exp=ffff", signature); end
        checks++; if (error !== 1'b0) begin failures++; $display("FAIL reset_error got=%0b exp=0", error); end
    endtask

    task automatic test_exhaustive;
        bit ok;
        int bad;
        logic [15:0] sig;
        resp_delay = 1; resp_lsb = 1'b0; rdy_pat = 1'b0; resp_en = 1'b1;
        do_start(1'b0, 8'h00);
        checks++; if (busy !== 1'b1) begin failures++; $display("FAIL exh_busy got=%0b exp=1", busy); end
        wait_done(2000, ok);
        checks++; if (!ok) begin failures++; $display("FAIL exh_timeout got=done0 exp=done1"); end
        checks++; if (vlog.size() != 256) begin failures++; $display("FAIL exh_count got=%0d exp=256", vlog.size()); end
        bad = 0;
        sig = 16'hFFFF;
        for (int i = 0; i < vlog.size(); i++) begin
            if (vlog[i] !== 8'(i)) bad++;
            sig = misr_model(sig, 1'b1);
        end
        checks++; if (bad != 0) begin failures++; $display("FAIL exh_sequence got=%0d_bad exp=0_bad", bad); end
        checks++; if (clog.size() == 256 && (clog[255] - clog[0]) != 255) begin failures++; $display("FAIL exh_gapless got=%0d exp=255", clog[255] - clog[0]); end
        checks++; if (hit_count !== 9'd256 || resp_count !== 9'd256) begin failures++; $display("FAIL exh_counts got=%0d/%0d exp=256/256", hit_count, resp_count); end
        checks++; if (signature !== sig) begin failures++; $display("FAIL exh_signature got=%0h exp=%0h", signature, sig); end
        checks++; if (error !== 1'b0 || busy !== 1'b0) begin failures++; $display("FAIL exh_err_busy got=%0b%0b exp=00", error, busy); end
        repeat (3) @(negedge clk);
        checks++; if (done !== 1'b1 || resp_count !== 9'd256) begin failures++; $display("FAIL exh_hold got=%0b/%0d exp=1/256", done, resp_count); end
    endtask

    task automatic test_back_to_back_backpressure;
        bit ok;
        int bad;
        resp_delay = 2; resp_lsb = 1'b1; rdy_pat = 1'b1; resp_en = 1'b1;
        do_start(1'b0, 8'h00);
        wait_done(4000, ok);
        checks++; if (!ok) begin failures++; $display("FAIL bp_timeout got=done0 exp=done1"); end
        checks++; if (stable_viol != 0) begin failures++; $display("FAIL bp_stable got=%0d exp=0", stable_viol); end
        bad = 0;
        for (int i = 0; i < vlog.size(); i++)
            if (vlog[i] !== 8'(i)) bad++;
        checks++; if (vlog.size() != 256 || bad != 0) begin failures++; $display("FAIL bp_sequence got=%0d/%0d exp=256/0", vlog.size(), bad); end
        checks++; if (resp_count !== 9'd256 || hit_count !== 9'd128) begin failures++; $display("FAIL bp_counts got=%0d/%0d exp=256/128", resp_count, hit_count); end
        rdy_pat = 1'b0;
    endtask

    task automatic test_lfsr;
        bit ok;
        int bad;
        bit seen[256];
        logic [15:0] sig;
        resp_delay = 3; resp_lsb = 1'b1; rdy_pat = 1'b0; resp_en = 1'b1;
        do_start(1'b1, 8'h00);
        wait_done(2000, ok);
        checks++; if (!ok) begin failures++; $display("FAIL lfsr_timeout got=done0 exp=done1"); end
        checks++; if (vlog.size() < 3 || vlog[0] !== 8'h01 || vlog[1] !== 8'hB8 || vlog[2] !== 8'h5C) begin
            failures++; $display("FAIL lfsr_first got=%0d_vectors exp=01,b8,5c", vlog.size());
        end
        bad = 0;
        sig = 16'hFFFF;
        foreach (seen[i]) seen[i] = 1'b0;
        for (int i = 0; i < vlog.size(); i++) begin
            if (vlog[i] == 8'h00 || seen[vlog[i]]) bad++;
            seen[vlog[i]] = 1'b1;
            sig = misr_model(sig, vlog[i][0]);
        end
        checks++; if (vlog.size() != 255 || bad != 0) begin failures++; $display("FAIL lfsr_distinct got=%0d/%0d exp=255/0", vlog.size(), bad); end
        checks++; if (resp_count !== 9'd255 || hit_count !== 9'd128) begin failures++; $display("FAIL lfsr_counts got=%0d/%0d exp=255/128", resp_count, hit_count); end
        checks++; if (signature !== sig) begin failures++; $display("FAIL lfsr_signature got=%0h exp=%0h", signature, sig); end
    endtask

    task automatic test_outstanding_cap;
        bit ok;
        resp_delay = 10; resp_lsb = 1'b0; rdy_pat = 1'b0; resp_en = 1'b1;
        do_start(1'b0, 8'h00);
        repeat (6) @(negedge clk);
        checks++; if (vlog.size() != 4) begin failures++; $display("FAIL cap_transfers got=%0d exp=4", vlog.size()); end
        checks++; if (vec_valid !== 1'b0) begin failures++; $display("FAIL cap_valid_low got=%0b exp=0", vec_valid); end
        wait_done(6000, ok);
        checks++; if (!ok) begin failures++; $display("FAIL cap_timeout got=done0 exp=done1"); end
        checks++; if (max_out != 4) begin failures++; $display("FAIL cap_max_outstanding got=%0d exp=4", max_out); end
        checks++; if (resp_count !== 9'd256) begin failures++; $display("FAIL cap_resp_count got=%0d exp=256", resp_count); end
    endtask

    task automatic test_spurious;
        bit ok;
        @(negedge clk);
        rst = 1'b1;
        repeat (2) @(negedge clk);
        #1 rst = 1'b0;
        resp_en = 1'b0;
        @(negedge clk);
        res_valid = 1'b1;
        res_bit = 1'b1;
        @(negedge clk);
        res_valid = 1'b0;
        @(negedge clk);
        checks++; if (error !== 1'b1) begin failures++; $display("FAIL spur_error got=%0b exp=1", error); end
        checks++; if (resp_count !== 9'd0 || hit_count !== 9'd0) begin failures++; $display("FAIL spur_counts got=%0d/%0d exp=0/0", resp_count, hit_count); end
        checks++; if (signature !== 16'hFFFF) begin failures++; $display("FAIL spur_signature got=%0h exp=ffff", signature); end
        resp_en = 1'b1; resp_delay = 1; resp_lsb = 1'b0;
        do_start(1'b0, 8'h00);
        checks++; if (error !== 1'b0) begin failures++; $display("FAIL spur_cleared got=%0b exp=0", error); end
        wait_done(2000, ok);
        checks++; if (!ok) begin failures++; $display("FAIL spur_timeout got=done0 exp=done1"); end
    endtask

    task automatic test_reset_midrun;
        bit ok;
        resp_delay = 1; resp_lsb = 1'b0; rdy_pat = 1'b0; resp_en = 1'b1;
        do_start(1'b0, 8'h00);
        ok = 1'b0;
        for (int i = 0; i < 200; i++) begin
            if (vlog.size() >= 37) begin
                ok = 1'b1;
                break;
            end
            @(negedge clk);
        end
        checks++; if (!ok) begin failures++; $display("FAIL mid_reach37 got=%0d exp=37", vlog.size()); end
        @(posedge clk);
        #2 rst = 1'b1;
        #1;
        checks++; if (vec_valid !== 1'b0 || vec_data !== 8'h00) begin failures++; $display("FAIL mid_vec got=%0b/%0h exp=0/0", vec_valid, vec_data); end
        checks++; if (busy !== 1'b0 || done !== 1'b0) begin failures++; $display("FAIL mid_state got=%0b%0b exp=00", busy, done); end
        checks++; if (hit_count !== 9'd0 || resp_count !== 9'd0 || signature !== 16'hFFFF || error !== 1'b0) begin
            failures++; $display("FAIL mid_outputs got=%0d/%0d/%0h/%0b exp=0/0/ffff/0", hit_count, resp_count, signature, error);
        end
        repeat (2) @(negedge clk);
        #1 rst = 1'b0;
        do_start(1'b0, 8'h00);
        wait_done(2000, ok);
        checks++; if (!ok) begin failures++; $display("FAIL mid_timeout got=done0 exp=done1"); end
        checks++; if (vlog.size() != 256 || vlog[0] !== 8'h00) begin failures++; $display("FAIL mid_restart got=%0d_vectors exp=256_from_0", vlog.size()); end
        checks++; if (resp_count !== 9'd256 || error !== 1'b0) begin failures++; $display("FAIL mid_counts got=%0d/%0b exp=256/0", resp_count, error); end
    endtask

    initial begin
        test_reset;
        test_exhaustive;
        test_back_to_back_backpressure;
        test_lfsr;
        test_outstanding_cap;
        test_spurious;
        test_reset_midrun;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/hd_vector_driver.md
Name: hd_vector_driver

Overview:
- Sequential stimulus source and response collector for the 8-input single-output combinational predicate benchmarks in this suite.
- Issues input words to a predicate under test over a valid/ready handshake, then collects its one-bit responses.
- Reports the hit count, the response count and a 16-bit signature, so that optimized and reference netlists can be compared in hardware.

Parameters:
- WIDTH, 8, width of each issued vector (predicate input count).
- POLY, 8'hB8, Galois right-shift LFSR tap mask. Used in LFSR mode; must be maximal-length for WIDTH.
- MAX_OUT, 4, maximum number of accepted vectors awaiting a response (1..15).

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- start  in  1  one-cycle pulse; begins a run from IDLE or DONE; ignored while busy.
- mode  in  1  0 = exhaustive sweep, 1 = LFSR sweep.
- seed  in  WIDTH  LFSR start value, sampled on start; 0 is replaced by 1.
- vec_valid  out  1  vector available.
- vec_data  out  WIDTH  vector to the predicate under test.
- vec_ready  in  1  predicate side accepts vec_data.
- res_valid  in  1  response strobe.
- res_bit  in  1  predicate output for the oldest outstanding vector.
- busy  out  1  high in ISSUE and DRAIN.
- done  out  1  high (level) in DONE.
- hit_count  out  WIDTH+1  number of responses with res_bit = 1.
- resp_count  out  WIDTH+1  number of counted responses.
- signature  out  16  response signature (MISR).
- error  out  1  sticky; set by a response arriving with no vector outstanding.

Behaviour:
- Reset (async, any time, including mid-run):
  - state = IDLE; vec_valid = 0; vec_data = 0; busy = 0; done = 0.
  - hit_count = 0; resp_count = 0; signature = 16'hFFFF; error = 0; outstanding = 0.
- States:
  - IDLE -start-> ISSUE.
  - ISSUE -last handshake-> DRAIN.
  - DRAIN -outstanding == 0-> DONE.
  - DONE -start-> ISSUE.
- On start:
  - Clear hit_count, resp_count and error; signature = 16'hFFFF.
  - Exhaustive: first vector = 0; total N = 2^WIDTH.
  - LFSR: first vector = (seed == 0 ? 1 : seed); total N = 2^WIDTH - 1.
- Handshake: a transfer occurs when vec_valid & vec_ready on a rising edge.
  - Once asserted, vec_valid and vec_data hold stable until the transfer.
  - vec_valid is raised only in ISSUE and only when outstanding < MAX_OUT.
  - After a transfer, the next vector may be presented in the following cycle, giving zero-bubble throughput of 1 vector/cycle.
- Next vector:
  - Exhaustive: vec_data + 1.
  - LFSR: (v >> 1) ^ (v[0] ? POLY : 0).
  - Issue count reaching N ends ISSUE; vec_valid drops in the cycle after the last transfer.
- Outstanding counter: +1 per transfer, -1 per counted response. A simultaneous transfer and response leaves it unchanged.
- Response with outstanding > 0 (any state):
  - resp_count += 1.
  - hit_count += res_bit.
  - signature = {signature[14:0], 1'b0} ^ (signature[15] ? 16'h1021 : 0) ^ {15'b0, res_bit}.
- Response with outstanding == 0 (including in IDLE/DONE): error = 1; counts and signature unchanged.
- Counter widths: WIDTH+1 bits, so the value 2^WIDTH is representable; no wrap within a run.
- Latency of the predicate under test is arbitrary; responses are in issue order.
- Outputs hold their values in DONE until the next start or reset.

Test Plan:
- Exhaustive run: mode = 0, vec_ready = 1, checker echoes res_bit = 1 one cycle after each transfer -> vec_data sequence 0x00..0xFF with no gaps; done set; hit_count = 256; resp_count = 256; error = 0.
- Backpressure: vec_ready toggles 1,0,0,1 repeatedly -> vec_data never changes while vec_valid & !vec_ready; no vector lost or duplicated; resp_count = 256.
- LFSR mode, seed = 0 -> first vectors 0x01, 0xB8, 0x5C; 255 distinct nonzero vectors; resp_count = 255; done set.
- Outstanding cap: vec_ready = 1, responses delayed by 10 cycles -> exactly 4 transfers, then vec_valid = 0 until the first response; outstanding never exceeds 4.
- Spurious response: res_valid pulse while in IDLE -> error = 1; resp_count = 0; signature = 16'hFFFF. A subsequent start clears error.
- Reset mid-run: assert rst after 37 transfers -> all outputs return to reset values asynchronously; the next start restarts at vector 0.
